// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
// Shadow-entry layout, FSM states and forwarding select codes.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              load;
    } shadow_t;

    localparam shadow_t SHADOW_NONE = '0;

    // Newest producer wins; x0 never produces a forwardable value.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input shadow_t           mem,
        input shadow_t           wb
    );
        if (mem.wr && mem.rd != '0 && mem.rd == rs) return FWD_MEM;
        if (wb.wr && wb.rd != '0 && wb.rd == rs) return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_shadow.sv
// One shadow pipeline entry tracking hazard fields of a stage.
// Advances with its register enable; a flush loads an empty entry.
module hazard_shadow_stage
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    en,
    input  logic    flush,
    input  shadow_t d,
    output shadow_t q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= SHADOW_NONE;
        end else if (en) begin
            q <= flush ? SHADOW_NONE : d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32I pipeline.
// Tracks rd/rs/wr/load of EX, MEM and WB in private shadow entries.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int REG_AW = pipe_hazard_ctrl_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic              id_jump,
    input  logic              ex_br_taken,
    input  logic              dmem_req,
    input  logic              dmem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    hz_state_t state, state_nx;
    shadow_t   id_d, ex_q, mem_q, wb_q;
    logic      mem_stall;
    logic      load_use;
    logic      unused_fields;

    assign id_d = '{
        rs1:  id_rs1,
        rs2:  id_rs2,
        rd:   id_rd,
        wr:   id_valid & id_reg_wr,
        load: id_valid & id_mem_rd
    };

    // The wait is entered combinationally so its first cycle already freezes.
    assign mem_stall = ((state == ST_MEM_WAIT) || dmem_req) && !dmem_ready;

    assign load_use = ex_q.load && ex_q.wr && (ex_q.rd != '0) && id_valid
                   && ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_RUN:      if (dmem_req && !dmem_ready) state_nx = ST_MEM_WAIT;
            ST_MEM_WAIT: if (dmem_ready) state_nx = ST_RUN;
            default:     state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b0;
        idex_en    = 1'b1;
        idex_flush = 1'b0;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        priority case (1'b1)
            mem_stall: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            ex_br_taken: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            load_use: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            (id_valid && id_jump): begin
                ifid_flush = 1'b1;
            end
            default: ;
        endcase
    end

    assign fwd_a = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign fwd_b = fwd_sel(ex_q.rs2, mem_q, wb_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            stall_cnt <= '0;
        end else begin
            state <= state_nx;
            if (!pc_en && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    hazard_shadow_stage u_ex (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (idex_en),
        .flush (idex_flush),
        .d     (id_d),
        .q     (ex_q)
    );

    hazard_shadow_stage u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (exmem_en),
        .flush (1'b0),
        .d     (ex_q),
        .q     (mem_q)
    );

    hazard_shadow_stage u_wb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (memwb_en),
        .flush (1'b0),
        .d     (mem_q),
        .q     (wb_q)
    );

    assign unused_fields = ^{mem_q.rs1, mem_q.rs2, mem_q.load,
                             wb_q.rs1, wb_q.rs2, wb_q.load};

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
- Consumes the decoder's per-instruction control bits in ID, the branch resolution from EX and the data-memory handshake.
- Keeps its own shadow copies of rd/rs/write-enable per stage, so no pipeline register has to export hazard fields.
- Drives PC and pipeline-register enables/flushes and the EX operand forwarding selects.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_AW  ID source register 1.
- id_rs2  in  REG_AW  ID source register 2.
- id_rd  in  REG_AW  ID destination register.
- id_reg_wr  in  1  decoder reg_wr for the ID instruction.
- id_mem_rd  in  1  decoder mem_rd (load) for the ID instruction.
- id_jump  in  1  decoder jump (JAL/JALR), resolved in ID.
- ex_br_taken  in  1  branch in EX is taken.
- dmem_req  in  1  MEM stage is issuing a load/store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register loads a bubble.
- idex_en  out  1  ID/EX register enable.
- idex_flush  out  1  ID/EX register loads a bubble.
- exmem_en  out  1  EX/MEM register enable.
- memwb_en  out  1  MEM/WB register enable.
- fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- fwd_b  out  2  EX operand B select, same encoding as fwd_a.
- stall_cnt  out  CNT_W  saturating count of non-advancing cycles.

Behaviour:
- Reset is synchronous, sampled at the clk edge with rst_n=0.
  - All shadow stage entries are cleared (wr=0, rd=0, load=0).
  - State is RUN and stall_cnt=0.
  - Until the next edge, all *_en=1, all flushes=0 and fwd_a=fwd_b=00.
- Shadow stages EX, MEM and WB hold rs1, rs2, rd, wr and load.
  - They advance with the matching register enables.
  - A flushed or stalled slot enters as wr=0, load=0.
  - An entry with rd=0 is never a hazard or forward source.
- States: RUN and MEM_WAIT.
  - RUN -> MEM_WAIT when dmem_req=1 and dmem_ready=0.
  - MEM_WAIT -> RUN in the cycle dmem_ready=1.
  - In MEM_WAIT all enables are 0, flushes are 0 and the shadows hold. The response is combinational, so the freeze holds in the first waiting cycle too.
- Priority, highest first, evaluated combinationally each cycle:
  1. Memory wait (state MEM_WAIT or the entry condition): all enables 0.
  2. ex_br_taken: pc_en=1, ifid_flush=1, idex_flush=1. This kills the instructions in IF and ID; a load-use or jump in ID is discarded.
  3. Load-use: EX load=1, wr=1, rd!=0, id_valid=1, and rd equals id_rs1 or id_rs2.
     - pc_en=0, ifid_en=0, idex_flush=1.
     - Exactly one bubble; the next cycle forwards from MEM/WB.
  4. id_jump with id_valid=1: ifid_flush=1; ID/EX advances normally.
  5. Otherwise all enables are 1.
- Forwarding, computed from the EX shadow rs1/rs2:
  - 10 when the MEM entry has wr=1, rd!=0 and rd matches. This has priority over the WB match (newest value wins).
  - 01 when only the WB entry matches.
  - Otherwise 00.
- Regfile write-through in the same cycle is a regfile property, not handled here.
- stall_cnt increments on every cycle where pc_en=0 and saturates at all-ones.
- Latency: hazard outputs are combinational from inputs and current state; no added cycle.
- Reset mid-MEM_WAIT returns the block to RUN with empty shadows at that edge.

Decomposition:
- Shared package holds:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - State encoding ST_RUN, ST_MEM_WAIT.
  - REG_AW and the shadow-entry field layout.
- One natural sub-module, hazard_shadow_stage: a single shadow entry register with en/flush. It is instantiated three times.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all *_en=1, flushes=0, fwd=00, stall_cnt=0.
- Load-use: lw x5 in EX, ID reads rs1=x5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; the next cycle fwd_a=01; stall_cnt=1.
- Double forward: x3 written by the MEM and the WB entries, EX rs2=x3 -> fwd_b=10. With the MEM entry at rd=x0 instead -> fwd_b=01.
- Branch vs load-use: ex_br_taken=1 while a load-use is pending -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; stall_cnt unchanged.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, resume on the 4th; stall_cnt=3. Then assert rst_n=0 during a wait -> RUN and stall_cnt=0 at the next edge.
- Jump plus saturation: id_jump=1 -> ifid_flush=1 only. Force stall_cnt to 0xFFFF with a further stall -> it stays 0xFFFF.
